// File: rtl/crop_pkg.sv
// Shared constants and helpers for the crop window controller: default geometry,
// FSM state encodings and the coordinate clamp used when latching the window origin.
package crop_pkg;

    localparam int unsigned DEF_PIXEL_BIT_WIDTH = 10;
    localparam int unsigned DEF_IN_ROWS         = 20;
    localparam int unsigned DEF_IN_COLS         = 20;
    localparam int unsigned DEF_OUT_ROWS        = 10;
    localparam int unsigned DEF_OUT_COLS        = 10;

    localparam int unsigned COL_W = $clog2(DEF_IN_COLS);
    localparam int unsigned ROW_W = $clog2(DEF_IN_ROWS);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StActive = 1'b1;

    // One spare bit so origin + window size never wraps in the keep compare.
    function automatic int unsigned cmp_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    function automatic int unsigned clamp_coord(input int unsigned req, input int unsigned lim);
        return (req > lim) ? lim : req;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI Stream output register carrying tdata/tuser/tlast.
// Upstream may load whenever the slot is empty or being drained this cycle.
module axis_out_reg #(
    parameter int unsigned DataW = 10
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             load_i,
    input  logic [DataW-1:0] data_i,
    input  logic             user_i,
    input  logic             last_i,
    output logic             s_ready_o,
    input  logic             m_ready_i,
    output logic             m_valid_o,
    output logic [DataW-1:0] m_data_o,
    output logic             m_user_o,
    output logic             m_last_o
);

    logic             valid_q;
    logic [DataW-1:0] data_q;
    logic             user_q;
    logic             last_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            user_q  <= user_i;
            last_q  <= last_i;
        end else if (m_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    always_comb begin
        s_ready_o = !valid_q || m_ready_i;
        m_valid_o = valid_q;
        m_data_o  = data_q;
        m_user_o  = user_q;
        m_last_o  = last_q;
    end

endmodule

// File: rtl/crop_window_ctrl.sv
// Frame crop controller: tracks raster position of serialized pixels and forwards only the
// latched crop window. Optional frame counter output enabled by CROP_FRAME_CNT_EN.
module crop_window_ctrl
    import crop_pkg::*;
#(
    parameter int unsigned PIXEL_BIT_WIDTH = DEF_PIXEL_BIT_WIDTH,
    parameter int unsigned IN_ROWS         = DEF_IN_ROWS,
    parameter int unsigned IN_COLS         = DEF_IN_COLS,
    parameter int unsigned OUT_ROWS        = DEF_OUT_ROWS,
    parameter int unsigned OUT_COLS        = DEF_OUT_COLS
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic [$clog2(IN_COLS)-1:0]  crop_x0,
    input  logic [$clog2(IN_ROWS)-1:0]  crop_y0,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0]  s_axis_tdata,
    input  logic                        s_axis_tuser,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [PIXEL_BIT_WIDTH-1:0]  m_axis_tdata,
    output logic                        m_axis_tuser,
    output logic                        m_axis_tlast,
    output logic                        frame_done,
    output logic                        sof_err,
    output logic                        cfg_clamped
`ifdef CROP_FRAME_CNT_EN
    ,
    output logic [15:0]                 frame_cnt
`endif
);

    localparam int unsigned ColW    = $clog2(IN_COLS);
    localparam int unsigned RowW    = $clog2(IN_ROWS);
    localparam int unsigned ColCmpW = cmp_width(IN_COLS);
    localparam int unsigned RowCmpW = cmp_width(IN_ROWS);
    localparam int unsigned XMax    = IN_COLS - OUT_COLS;
    localparam int unsigned YMax    = IN_ROWS - OUT_ROWS;

    logic [0:0]      state_q, state_d;
    logic [RowW-1:0] row_q, row_d;
    logic [ColW-1:0] col_q, col_d;
    logic [ColW-1:0] x0_q, x0_d;
    logic [RowW-1:0] y0_q, y0_d;
    logic            clamped_q, clamped_d;
    logic            frame_done_q, frame_done_d;
    logic            sof_err_q, sof_err_d;

    logic               in_hs, sof, process, keep, last_pix;
    logic               out_user, out_last;
    logic [ColW-1:0]    x0_new, x0_eff, cur_col;
    logic [RowW-1:0]    y0_new, y0_eff, cur_row;
    logic [ColCmpW-1:0] col_c, x_lo, x_hi;
    logic [RowCmpW-1:0] row_c, y_lo, y_hi;

    always_comb begin
        in_hs   = s_axis_tvalid && s_axis_tready;
        sof     = in_hs && s_axis_tuser;
        process = in_hs && (sof || (state_q == StActive));

        x0_new  = ColW'(clamp_coord(32'(crop_x0), XMax));
        y0_new  = RowW'(clamp_coord(32'(crop_y0), YMax));
        // A SOF pixel is position (0,0) of the new frame and uses the freshly latched origin.
        x0_eff  = sof ? x0_new : x0_q;
        y0_eff  = sof ? y0_new : y0_q;
        cur_col = sof ? '0 : col_q;
        cur_row = sof ? '0 : row_q;

        col_c = ColCmpW'(cur_col);
        x_lo  = ColCmpW'(x0_eff);
        x_hi  = x_lo + ColCmpW'(OUT_COLS);
        row_c = RowCmpW'(cur_row);
        y_lo  = RowCmpW'(y0_eff);
        y_hi  = y_lo + RowCmpW'(OUT_ROWS);

        keep     = process && (row_c >= y_lo) && (row_c < y_hi) && (col_c >= x_lo) && (col_c < x_hi);
        out_user = (row_c == y_lo) && (col_c == x_lo);
        out_last = (col_c == x_hi - ColCmpW'(1));
        last_pix = (cur_row == RowW'(IN_ROWS - 1)) && (cur_col == ColW'(IN_COLS - 1));
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        clamped_d    = clamped_q;
        frame_done_d = 1'b0;
        sof_err_d    = sof && (state_q == StActive);

        if (sof) begin
            x0_d      = x0_new;
            y0_d      = y0_new;
            clamped_d = (32'(crop_x0) > XMax) || (32'(crop_y0) > YMax);
        end

        if (process) begin
            if (last_pix) begin
                state_d      = StIdle;
                row_d        = '0;
                col_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                state_d = StActive;
                if (cur_col == ColW'(IN_COLS - 1)) begin
                    col_d = '0;
                    row_d = cur_row + RowW'(1);
                end else begin
                    col_d = cur_col + ColW'(1);
                    row_d = cur_row;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= StIdle;
            row_q        <= '0;
            col_q        <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            clamped_q    <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            clamped_q    <= clamped_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

    axis_out_reg #(
        .DataW (PIXEL_BIT_WIDTH)
    ) u_out_reg (
        .clk_i     (clk),
        .srst_i    (srst),
        .load_i    (keep),
        .data_i    (s_axis_tdata),
        .user_i    (out_user),
        .last_i    (out_last),
        .s_ready_o (s_axis_tready),
        .m_ready_i (m_axis_tready),
        .m_valid_o (m_axis_tvalid),
        .m_data_o  (m_axis_tdata),
        .m_user_o  (m_axis_tuser),
        .m_last_o  (m_axis_tlast)
    );

    always_comb begin
        frame_done  = frame_done_q;
        sof_err     = sof_err_q;
        cfg_clamped = clamped_q;
    end

`ifdef CROP_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            frame_cnt_q <= '0;
        end else if (frame_done_d) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    always_comb frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/crop_window_ctrl.md
Name: crop_window_ctrl

Overview:
Frame-level crop controller placed directly after the burst-to-pixel sequentializer. It tracks the row/column of every serialized pixel, latches crop coordinates once per frame, and forwards only the OUT_ROWS x OUT_COLS window to the downstream AXI Stream. Window pixels are marked with start-of-frame (tuser) and end-of-line (tlast); all other pixels are consumed and discarded.

Parameters:
PIXEL_BIT_WIDTH, 10, bits per pixel
IN_ROWS, 20, rows per input frame
IN_COLS, 20, columns per input frame
OUT_ROWS, 10, rows in crop window (<= IN_ROWS)
OUT_COLS, 10, columns in crop window (<= IN_COLS)

Ports:
clk  in  1  single clock
srst  in  1  synchronous reset, active-high
crop_x0  in  $clog2(IN_COLS)  requested window left column
crop_y0  in  $clog2(IN_ROWS)  requested window top row
s_axis_tvalid  in  1  input pixel valid
s_axis_tready  out  1  input pixel ready
s_axis_tdata  in  PIXEL_BIT_WIDTH  input pixel
s_axis_tuser  in  1  start-of-frame, set on pixel (0,0)
m_axis_tvalid  out  1  output pixel valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  PIXEL_BIT_WIDTH  cropped pixel
m_axis_tuser  out  1  first window pixel of a frame
m_axis_tlast  out  1  last window pixel of a row
frame_done  out  1  one-cycle pulse after the last input pixel of a frame
sof_err  out  1  one-cycle pulse when SOF arrives mid-frame
cfg_clamped  out  1  sticky per frame: latched coordinates were clamped

Behaviour:
- Reset: state=IDLE. Counters, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, frame_done, sof_err and cfg_clamped are all 0.
- Input handshake: s_axis_tready = !m_axis_tvalid || m_axis_tready in every state. This makes a single output register. Dropped pixels also require tready, so ordering is preserved.
- FSM states: IDLE and ACTIVE.
  - IDLE: accepted pixels without tuser are discarded. An accepted pixel with tuser is treated as (row 0, col 0). On that pixel: latch the coordinates, process the pixel, then go to ACTIVE.
  - ACTIVE: each accepted pixel advances col. When col = IN_COLS-1, col wraps to 0 and row increments.
  - Accepting pixel (IN_ROWS-1, IN_COLS-1) returns the FSM to IDLE and pulses frame_done on the next cycle.
- Coordinate latch, once per SOF:
  - x0_l = min(crop_x0, IN_COLS-OUT_COLS); y0_l = min(crop_y0, IN_ROWS-OUT_ROWS).
  - cfg_clamped = 1 if either value was clamped. It holds until the next SOF.
  - crop_x0/crop_y0 changes mid-frame have no effect.
- Keep condition: y0_l <= row < y0_l+OUT_ROWS and x0_l <= col < x0_l+OUT_COLS. Compare at widths wide enough that the sums do not overflow.
- Output register:
  - A kept pixel loads m_axis_tdata and sets m_axis_tvalid.
  - m_axis_tuser = (row==y0_l && col==x0_l).
  - m_axis_tlast = (col==x0_l+OUT_COLS-1).
  - tvalid clears on handshake when no new kept pixel is loaded that cycle.
  - Latency is 1 cycle from input handshake to m_axis_tvalid.
- Downstream stall: m_axis_tvalid and m_axis_tdata/tuser/tlast are held stable while m_axis_tready=0. s_axis_tready=0 during the stall.
- Simultaneous events: an output handshake and a kept input pixel in the same cycle reload the register with no bubble.
- SOF in ACTIVE: the pixel is treated as a new (0,0), coordinates are re-latched, and sof_err pulses. A pending output word is not discarded.
- SOF on the final pixel of a frame: sof_err pulses, and that pixel starts the new frame.
- Reset mid-frame: the pending output is dropped and the block returns to IDLE.

Optional Feature:
CROP_FRAME_CNT_EN
- Defined: adds output frame_cnt[15:0]. It increments on each frame_done, wraps 0xFFFF->0, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package crop_pkg: state enum (IDLE, ACTIVE); localparams COL_W, ROW_W and the widened compare widths; clamp function.
- Sub-module axis_out_reg: one-entry AXIS register with tdata/tuser/tlast. It owns the valid/ready logic and the s_axis_tready expression.

Test Plan:
- Default params, crop=(5,5), data=raster index, m_axis_tready=1 -> 100 outputs. First output = 105 with tuser=1. tlast on 114, 134, ... 294. Last output = 294, then frame_done pulses once.
- crop_x0=15, crop_y0=18 -> clamped to (10,10), cfg_clamped=1. First output = 210, last = 399.
- Random m_axis_tready at 30% -> same 100-value sequence as the first test. No drop or duplicate. Output held stable while stalled.
- SOF reasserted at input pixel 150 -> sof_err pulse. The window restarts relative to pixel 150 (new (0,0)). The already-registered output still emits.
- Pixels before any SOF (37 junk words) -> all accepted, none output, FSM stays IDLE.
- srst asserted at input pixel 200, then a fresh frame -> m_axis_tvalid=0 the cycle after reset. The next frame gives a full correct 100-pixel window. With CROP_FRAME_CNT_EN, frame_cnt=1 after that frame.
